// File: rtl/pmem_arb_pkg.sv
// Shared types and defaults for the physical-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity (I-cache / D-cache)
package pmem_arb_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultLineW = 256;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (combinational).
//   i_active, d_active : requester active flags (stb & cyc)
//   last_grant         : requester granted most recently
//   grant_valid        : at least one requester active
//   grant_id           : chosen requester
module rr_pick2
  import pmem_arb_pkg::*;
(
  input  logic    i_active,
  input  logic    d_active,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = i_active | d_active;
    grant_id    = REQ_I;
    if (i_active && d_active) begin
      // Tie goes to whoever did not win last time.
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_active) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache.
// The winner's command is latched on grant and driven to memory until the
// transfer completes; resp/rdata are routed to the owner only, and any other
// active requester is held on retry.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_* / d_*           : cache-side request, write line, read line, resp, retry
//   mem_*               : memory-side command, write line, read line, resp, retry
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned LINE_W = DefaultLineW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_action_stb,
  input  logic              i_action_cyc,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  output logic              i_retry,
  input  logic              d_action_stb,
  input  logic              d_action_cyc,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              d_retry,
  output logic              mem_action_stb,
  output logic              mem_action_cyc,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  input  logic              mem_retry
);

  arb_state_t        state_q;
  req_id_t           last_grant_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic    i_active, d_active;
  logic    grant_valid;
  req_id_t grant_id;
  logic    in_grant;
  logic    mem_done;
  logic    i_done, d_done;

  assign i_active = i_action_stb & i_action_cyc;
  assign d_active = d_action_stb & d_action_cyc;

  rr_pick2 u_pick (
    .i_active    (i_active),
    .d_active    (d_active),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A beat flagged retry by memory is not a completion.
  assign mem_done = mem_resp & ~mem_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;  // I wins the first tie after reset
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_id;
            if (grant_id == REQ_I) begin
              state_q <= GRANT_I;
              write_q <= i_write;
              addr_q  <= i_address;
              wdata_q <= i_wdata;
            end else begin
              state_q <= GRANT_D;
              write_q <= d_write;
              addr_q  <= d_address;
              wdata_q <= d_wdata;
            end
          end
        end
        // Completion is honoured even if the owner has since dropped stb.
        GRANT_I, GRANT_D: if (mem_done) state_q <= RELEASE;
        RELEASE:          state_q <= IDLE;
        default:          state_q <= IDLE;
      endcase
    end
  end

  // Memory side is driven purely from state and latched command.
  assign in_grant       = (state_q == GRANT_I) | (state_q == GRANT_D);
  assign mem_action_stb = in_grant;
  assign mem_action_cyc = in_grant;
  assign mem_write      = in_grant & write_q;
  assign mem_address    = in_grant ? addr_q : '0;
  assign mem_wdata      = in_grant ? wdata_q : '0;

  assign i_done  = (state_q == GRANT_I) & mem_done;
  assign d_done  = (state_q == GRANT_D) & mem_done;
  assign i_resp  = i_done;
  assign d_resp  = d_done;
  assign i_rdata = i_done ? mem_rdata : '0;
  assign d_rdata = d_done ? mem_rdata : '0;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign i_retry = rst_n & i_active & ~i_done;
  assign d_retry = rst_n & d_active & ~d_done;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with hand-computed expectations.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_action_stb, i_action_cyc, i_write;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_wdata, i_rdata;
  logic              i_resp, i_retry;
  logic              d_action_stb, d_action_cyc, d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata, d_rdata;
  logic              d_resp, d_retry;
  logic              mem_action_stb, mem_action_cyc, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_resp, mem_retry;

  int n_tests = 0;
  int n_fail  = 0;

  pmem_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_action_stb   (i_action_stb),
    .i_action_cyc   (i_action_cyc),
    .i_write        (i_write),
    .i_address      (i_address),
    .i_wdata        (i_wdata),
    .i_rdata        (i_rdata),
    .i_resp         (i_resp),
    .i_retry        (i_retry),
    .d_action_stb   (d_action_stb),
    .d_action_cyc   (d_action_cyc),
    .d_write        (d_write),
    .d_address      (d_address),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_resp         (d_resp),
    .d_retry        (d_retry),
    .mem_action_stb (mem_action_stb),
    .mem_action_cyc (mem_action_cyc),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .mem_retry      (mem_retry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic act, input logic wr, input logic [31:0] addr);
    i_action_stb = act;
    i_action_cyc = act;
    i_write      = wr;
    i_address    = addr;
  endtask

  task automatic set_d(input logic act, input logic wr, input logic [31:0] addr);
    d_action_stb = act;
    d_action_cyc = act;
    d_write      = wr;
    d_address    = addr;
  endtask

  logic [LINE_W-1:0] aa_line, line55, line5a, c3_line;
  logic              own_i;

  initial begin
    aa_line = {32{8'hAA}};
    line55  = {32{8'h55}};
    line5a  = {32{8'h5A}};
    c3_line = {32{8'hC3}};
    rst_n = 1'b0;
    set_i(1'b0, 1'b0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0);
    i_wdata = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0; mem_retry = 1'b0;

    // Reset state, even with a requester active.
    repeat (2) step();
    set_i(1'b1, 1'b0, 32'h100);
    #1;
    check("rst_mem_stb", mem_action_stb, 0);
    check("rst_mem_cyc", mem_action_cyc, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_i_retry", i_retry, 0);
    check("rst_i_resp", i_resp, 0);
    set_i(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();

    // Single I read of 0x100.
    set_i(1'b1, 1'b0, 32'h100);
    #1;
    check("rd_n_stb", mem_action_stb, 0);
    check("rd_n_retry", i_retry, 1);
    step();
    check("rd_stb", mem_action_stb, 1);
    check("rd_cyc", mem_action_cyc, 1);
    check("rd_write", mem_write, 0);
    check("rd_addr", mem_address, 32'h100);
    check("rd_wait_resp", i_resp, 0);
    check("rd_wait_retry", i_retry, 1);
    step();
    check("rd_wait2_resp", i_resp, 0);
    step();
    mem_resp = 1'b1; mem_rdata = aa_line;
    #1;
    check("rd_resp", i_resp, 1);
    check("rd_rdata", i_rdata, aa_line);
    check("rd_resp_retry", i_retry, 0);
    check("rd_d_resp", d_resp, 0);
    step();
    mem_resp = 1'b0;
    set_i(1'b0, 1'b0, 32'h0);
    #1;
    check("rd_rel_stb", mem_action_stb, 0);
    check("rd_rel_resp", i_resp, 0);
    check("rd_rel_rdata", i_rdata, 0);
    step();
    check("rd_idle_stb", mem_action_stb, 0);

    // Short async reset pulse restores last_grant=D, so I wins the first tie.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();

    // Both active: strict I, D, I, D alternation over 8 transfers.
    set_i(1'b1, 1'b0, 32'h1000);
    set_d(1'b1, 1'b1, 32'h2000);
    d_wdata = line5a;
    for (int k = 0; k < 8; k++) begin
      own_i = (k % 2 == 0);
      step();
      check("alt_addr", mem_address, own_i ? 32'h1000 : 32'h2000);
      check("alt_write", mem_write, own_i ? 1'b0 : 1'b1);
      check("alt_other_retry", own_i ? d_retry : i_retry, 1);
      step();
      check("alt_other_noresp", own_i ? d_resp : i_resp, 0);
      check("alt_own_retry", own_i ? i_retry : d_retry, 1);
      mem_resp = 1'b1; mem_rdata = LINE_W'(k + 1);
      #1;
      check("alt_own_resp", own_i ? i_resp : d_resp, 1);
      check("alt_own_rdata", own_i ? i_rdata : d_rdata, LINE_W'(k + 1));
      check("alt_other_resp", own_i ? d_resp : i_resp, 0);
      check("alt_other_rdata", own_i ? d_rdata : i_rdata, 0);
      check("alt_other_retry2", own_i ? d_retry : i_retry, 1);
      step();
      mem_resp = 1'b0;
      #1;
      check("alt_rel_stb", mem_action_stb, 0);
      check("alt_rel_i_retry", i_retry, 1);
      check("alt_rel_d_retry", d_retry, 1);
      step();
    end
    set_i(1'b0, 1'b0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0);
    step();

    // D write-back held off by mem_retry; live input changes must not leak.
    set_d(1'b1, 1'b1, 32'h2000);
    d_wdata = line55;
    step();
    mem_retry = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r == 2) begin
        d_address = 32'h3000;
        d_wdata   = '0;
      end
      #1;
      check("wb_addr", mem_address, 32'h2000);
      check("wb_wdata", mem_wdata, line55);
      check("wb_write", mem_write, 1);
      check("wb_stb", mem_action_stb, 1);
      check("wb_noresp", d_resp, 0);
      step();
    end
    mem_retry = 1'b0;
    mem_resp  = 1'b1; mem_rdata = 256'h77;
    set_i(1'b1, 1'b0, 32'h500);  // arrives in the completion cycle
    #1;
    check("wb_resp", d_resp, 1);
    check("wb_addr_end", mem_address, 32'h2000);
    check("wb_i_retry", i_retry, 1);
    check("wb_i_resp", i_resp, 0);
    step();
    mem_resp = 1'b0;
    set_d(1'b0, 1'b0, 32'h0);
    #1;
    check("defer_rel_stb", mem_action_stb, 0);
    check("defer_rel_retry", i_retry, 1);
    step();
    check("defer_idle_stb", mem_action_stb, 0);
    step();
    check("defer_grant_stb", mem_action_stb, 1);
    check("defer_grant_addr", mem_address, 32'h500);
    mem_resp = 1'b1;
    #1;
    check("defer_resp", i_resp, 1);
    step();
    mem_resp = 1'b0;
    set_i(1'b0, 1'b0, 32'h0);
    step();

    // I drops stb mid-grant; transfer still completes with one resp pulse.
    set_i(1'b1, 1'b0, 32'h400);
    step();
    set_i(1'b0, 1'b0, 32'h0);
    #1;
    check("drop_stb", mem_action_stb, 1);
    check("drop_addr", mem_address, 32'h400);
    check("drop_retry", i_retry, 0);
    step();
    mem_resp = 1'b1; mem_rdata = c3_line;
    #1;
    check("drop_resp", i_resp, 1);
    check("drop_rdata", i_rdata, c3_line);
    step();
    // mem_resp held high: spurious in RELEASE and then in IDLE.
    check("spur_rel_i_resp", i_resp, 0);
    check("spur_rel_d_resp", d_resp, 0);
    check("spur_rel_stb", mem_action_stb, 0);
    step();
    check("spur_idle_i_resp", i_resp, 0);
    check("spur_idle_d_resp", d_resp, 0);
    check("spur_idle_i_rdata", i_rdata, 0);
    check("spur_idle_d_rdata", d_rdata, 0);
    step();
    mem_resp = 1'b0;
    #1;
    check("spur_after_stb", mem_action_stb, 0);

    // Reset mid-grant drops the memory command immediately.
    set_i(1'b1, 1'b0, 32'h600);
    step();
    check("mid_pre_stb", mem_action_stb, 1);
    set_d(1'b1, 1'b0, 32'h700);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb", mem_action_stb, 0);
    check("mid_rst_cyc", mem_action_cyc, 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_i_retry", i_retry, 0);
    check("mid_rst_d_retry", d_retry, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_tie_addr", mem_address, 32'h600);
    check("post_rst_tie_d_retry", d_retry, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
